uivtc_pattern_gen: RTL
======================

Name: uivtc_pattern_gen

Overview:
- Video timing controller plus test-pattern source, one pixel per clock.
- Drives VS/HS/VDE and 24-bit RGB (R[23:16], G[15:8], B[7:0]) straight into the HDMI/DVI transmit stage.
- Used for bring-up and as a fallback source when the camera pipeline is not streaming.
- Runs only in the pixel clock domain. Starts and stops only on frame boundaries.

Parameters:
- H_ACTIVE, 1280, active pixels per line (must be a multiple of 8)
- H_FP, 110, horizontal front porch in clocks
- H_SYNC, 40, HS pulse width in clocks
- H_BP, 220, horizontal back porch in clocks
- V_ACTIVE, 720, active lines per frame
- V_FP, 5, vertical front porch in lines
- V_SYNC, 5, VS pulse width in lines
- V_BP, 20, vertical back porch in lines
- HS_POL, 1, HS asserted level (1 = active high)
- VS_POL, 1, VS asserted level

Ports:
- PCLK_i  in  1  pixel clock
- RSTn_i  in  1  reset; asynchronous assert, active-low
- EN_i  in  1  run request; level-sensitive
- PAT_i  in  2  pattern select: 0 colour bars, 1 grey ramp, 2 grid, 3 solid fill
- FILL_i  in  24  solid-fill colour for PAT_i = 3
- VS_o  out  1  vertical sync at VS_POL
- HS_o  out  1  horizontal sync at HS_POL
- VDE_o  out  1  active video
- RGB_o  out  24  pixel data; 0 whenever VDE_o = 0
- X_o  out  12  active x of the current RGB_o; 0 outside active video
- Y_o  out  12  active y of the current RGB_o; 0 outside active video
- SOF_o  out  1  one-cycle pulse aligned with the first active pixel of each frame
- BUSY_o  out  1  1 while in RUN or DRAIN

Behaviour:
- Reset (asynchronous, RSTn_i low):
  - State IDLE; all counters 0.
  - VS_o = !VS_POL, HS_o = !HS_POL.
  - VDE_o, RGB_o, X_o, Y_o, SOF_o, BUSY_o all 0.
- Counters:
  - H_TOTAL = sum of the four H parameters; V_TOTAL = sum of the four V parameters.
  - h_cnt runs 0..H_TOTAL-1 and wraps to 0.
  - v_cnt increments when h_cnt wraps, runs 0..V_TOTAL-1, and wraps to 0.
  - Counter widths come from $clog2 of the totals.
- Region decode:
  - Active when h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
  - HS asserted for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - VS asserted for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC. VS changes only at h_cnt = 0.
- Latency:
  - All outputs are registered, exactly 1 clock after the counter value they decode.
  - VS, HS, VDE, RGB, X, Y and SOF all sit in the same pipeline stage, so they stay mutually aligned.
- State machine:
  - IDLE: counters held at 0; sync outputs at their inactive level.
    - Go to RUN when EN_i = 1. The first RUN cycle has h_cnt = 0, v_cnt = 0.
  - RUN: counters free-run.
    - If EN_i = 0 is sampled at any point, go to DRAIN.
  - DRAIN: counters keep running until the frame ends (h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1).
    - At frame end: go to IDLE if EN_i = 0, otherwise go to RUN with no gap.
    - The last frame is always complete; no truncated frame is ever emitted.
- PAT_i and FILL_i:
  - Sampled only when entering RUN and at each frame wrap.
  - Mid-frame changes are ignored until the next frame.
- Patterns (x, y are active coordinates):
  - Colour bars: 8 equal bars of H_ACTIVE/8 pixels, in order FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000. Bar index comes from a bar-width sub-counter; no multiplier.
  - Grey ramp: R = G = B = x[7:0].
  - Grid: FFFFFF when x[4:0] = 0 or y[4:0] = 0, else 000000.
  - Solid: the latched FILL_i value.
- Boundary conditions:
  - EN_i toggling high then low within one frame still yields exactly one full frame.
  - Reset asserted mid-frame forces the reset values immediately, with no drain.

Decomposition:
- Shared package uivtc_pkg holds:
  - pattern-code constants PAT_BARS = 0, PAT_RAMP = 1, PAT_GRID = 2, PAT_FILL = 3;
  - the 8-entry colour-bar constant table;
  - the state encoding IDLE / RUN / DRAIN.
- One sub-module, uipattern_rgb:
  - Combinational pixel-colour function of (pat, x, y, bar_idx, fill).
  - Its output is registered in the parent, keeping it in the same pipeline stage as VS/HS/VDE.

Test Plan:
- Bench parameters for all scenarios:
  - H_ACTIVE = 16, H_FP = 2, H_SYNC = 3, H_BP = 3 (H_TOTAL = 24);
  - V_ACTIVE = 4, V_FP = 1, V_SYNC = 2, V_BP = 1 (V_TOTAL = 8);
  - HS_POL = VS_POL = 1.
- Timing: EN_i = 1 from reset -> VDE_o high 16 of every 24 clocks for 4 lines per 192-clock frame; HS_o high 3 clocks, starting 2 clocks after VDE_o falls; VS_o high for lines 5-6; SOF_o every 192 clocks.
- Colour bars: PAT_i = 0 -> RGB_o in 2-pixel pairs FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000 on every active line; RGB_o = 0 while VDE_o = 0.
- Ramp and grid: PAT_i = 1 -> RGB_o = {x, x, x} for x = 0..15. PAT_i = 2 -> row y = 0 all FFFFFF; rows 1-3 have FFFFFF only at x = 0.
- Mid-frame pattern change: PAT_i changes 3 to 1 at line 2, with FILL_i = 123456 -> rest of that frame stays 123456; the next frame is the ramp.
- Drain: EN_i dropped at clock 50 of a frame -> frame completes (192 clocks total), then BUSY_o = 0, VDE_o stays 0 and HS_o/VS_o stay low. Re-raising EN_i during DRAIN -> next frame follows with no gap.
- Reset mid-frame: RSTn_i low at clock 100 -> outputs are at reset values in the same cycle. After release with EN_i = 1, the first SOF_o is followed by a full, correct frame.

Source files
------------

// File: rtl/uivtc_pkg.sv
// uivtc_pkg: shared pattern codes, colour-bar table and controller state encoding
package uivtc_pkg;
  localparam logic [1:0] PAT_BARS = 2'd0;
  localparam logic [1:0] PAT_RAMP = 2'd1;
  localparam logic [1:0] PAT_GRID = 2'd2;
  localparam logic [1:0] PAT_FILL = 2'd3;
  localparam logic [23:0] BAR_RGB [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
endpackage

// File: rtl/uipattern_rgb.sv
// uipattern_rgb: combinational pixel colour for the selected test pattern
module uipattern_rgb
  import uivtc_pkg::*;
(
  input  logic [1:0]  i_pat,
  input  logic [7:0]  i_x,
  input  logic [4:0]  i_y,
  input  logic [2:0]  i_bar_idx,
  input  logic [23:0] i_fill,
  output logic [23:0] o_rgb
);
  // grid lines every 32 pixels in both directions, ramp follows the low x byte
  always_comb begin
    o_rgb = i_pat == PAT_FILL ? i_fill :
            i_pat == PAT_GRID ? ((i_x[4:0] == '0 || i_y == '0) ? 24'hFFFFFF : 24'h000000) :
            i_pat == PAT_RAMP ? {3{i_x}} :
            BAR_RGB[i_bar_idx];
  end
endmodule

// File: rtl/uivtc_pattern_gen.sv
// uivtc_pattern_gen: video timing controller with built-in test-pattern source
module uivtc_pattern_gen
  import uivtc_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic        PCLK_i,
  input  logic        RSTn_i,
  input  logic        EN_i,
  input  logic [1:0]  PAT_i,
  input  logic [23:0] FILL_i,
  output logic        VS_o,
  output logic        HS_o,
  output logic        VDE_o,
  output logic [23:0] RGB_o,
  output logic [11:0] X_o,
  output logic [11:0] Y_o,
  output logic        SOF_o,
  output logic        BUSY_o
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int BW = H_ACTIVE / 8;
  localparam int BCW = BW > 1 ? $clog2(BW) : 1;
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_ACT = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [BCW-1:0] BAR_LAST = BCW'(BW - 1);

  state_e          r_state;
  logic [HW-1:0]   r_h;
  logic [VW-1:0]   r_v;
  logic [BCW-1:0]  r_bar_cnt;
  logic [2:0]      r_bar_idx;
  logic [1:0]      r_pat;
  logic [23:0]     r_fill;
  logic            r_vs, r_hs, r_vde, r_sof;
  logic [23:0]     r_rgb;
  logic [11:0]     r_x, r_y;
  logic            w_run, w_h_end, w_frame_end, w_active, w_hs_on, w_vs_on;
  logic [11:0]     w_x, w_y;
  logic [23:0]     w_rgb;

  // region decode of the current counter values
  always_comb begin
    w_run       = r_state != IDLE;
    w_h_end     = r_h == H_LAST;
    w_frame_end = w_h_end && r_v == V_LAST;
    w_active    = w_run && r_h < H_ACT && r_v < V_ACT;
    w_hs_on     = w_run && r_h >= HS_BEG && r_h < HS_END;
    w_vs_on     = w_run && r_v >= VS_BEG && r_v < VS_END;
    w_x         = 12'(r_h);
    w_y         = 12'(r_v);
  end

  uipattern_rgb u_rgb (
    .i_pat     (r_pat),
    .i_x       (w_x[7:0]),
    .i_y       (w_y[4:0]),
    .i_bar_idx (r_bar_idx),
    .i_fill    (r_fill),
    .o_rgb     (w_rgb)
  );

  // run control and raster counters; pattern settings latch only at frame starts
  always_ff @(posedge PCLK_i or negedge RSTn_i) begin
    if (!RSTn_i) begin
      r_state   <= IDLE;
      r_h       <= '0;
      r_v       <= '0;
      r_bar_cnt <= '0;
      r_bar_idx <= '0;
      r_pat     <= PAT_BARS;
      r_fill    <= '0;
    end else if (r_state == IDLE) begin
      if (EN_i) begin
        r_state <= RUN;
        r_pat   <= PAT_i;
        r_fill  <= FILL_i;
      end
    end else begin
      r_h       <= w_h_end ? '0 : r_h + 1'b1;
      r_v       <= w_h_end ? (w_frame_end ? '0 : r_v + 1'b1) : r_v;
      r_bar_cnt <= (w_h_end || r_bar_cnt == BAR_LAST) ? '0 : r_bar_cnt + 1'b1;
      r_bar_idx <= w_h_end ? '0 : (r_bar_cnt == BAR_LAST ? r_bar_idx + 1'b1 : r_bar_idx);
      if (w_frame_end) begin
        r_state <= EN_i ? RUN : IDLE;
        r_pat   <= PAT_i;
        r_fill  <= FILL_i;
      end else if (!EN_i) begin
        r_state <= DRAIN;
      end
    end
  end

  // output stage: every video output one clock behind the counters it decodes
  always_ff @(posedge PCLK_i or negedge RSTn_i) begin
    if (!RSTn_i) begin
      r_vs  <= !VS_POL;
      r_hs  <= !HS_POL;
      r_vde <= 1'b0;
      r_rgb <= '0;
      r_x   <= '0;
      r_y   <= '0;
      r_sof <= 1'b0;
    end else begin
      r_vs  <= w_vs_on ~^ VS_POL;
      r_hs  <= w_hs_on ~^ HS_POL;
      r_vde <= w_active;
      r_rgb <= w_active ? w_rgb : '0;
      r_x   <= w_active ? w_x : '0;
      r_y   <= w_active ? w_y : '0;
      r_sof <= w_active && r_h == '0 && r_v == '0;
    end
  end

  assign VS_o   = r_vs;
  assign HS_o   = r_hs;
  assign VDE_o  = r_vde;
  assign RGB_o  = r_rgb;
  assign X_o    = r_x;
  assign Y_o    = r_y;
  assign SOF_o  = r_sof;
  assign BUSY_o = w_run;
endmodule
